// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// mthi/mtlo complete in one edge; mult/div hold busy for a fixed latency.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic          sgn;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [31:0]   q_u;
  logic [31:0]   r_u;
  logic          q_neg;
  logic          r_neg;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          res_keep;

  // Signed divide works on magnitudes so INT_MIN / -1 wraps cleanly.
  always_comb begin
    prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u   = {32'b0, a_q} * {32'b0, b_q};
    sgn      = (op_q == OP_DIV);
    mag_a    = (sgn && a_q[31]) ? -a_q : a_q;
    mag_b    = (sgn && b_q[31]) ? -b_q : b_q;
    q_u      = 32'd0;
    r_u      = 32'd0;
    if (b_q != 32'd0) begin
      q_u = mag_a / mag_b;
      r_u = mag_a % mag_b;
    end
    q_neg    = sgn & (a_q[31] ^ b_q[31]);
    r_neg    = sgn & a_q[31];
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    res_keep = 1'b0;
    unique case (1'b1)
      (op_q == OP_MULT): begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      (op_q == OP_MULTU): begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      (op_q == OP_DIV || op_q == OP_DIVU): begin
        res_hi   = r_neg ? -r_u : r_u;
        res_lo   = q_neg ? -q_u : q_u;
        res_keep = (b_q == 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            case (MDUOp)
              OP_MULT, OP_MULTU: begin
                state <= RUN;
                busy  <= 1'b1;
                cnt   <= CW'(MULT_CYCLES);
                op_q  <= MDUOp;
                a_q   <= A;
                b_q   <= B;
              end
              OP_DIV, OP_DIVU: begin
                state <= RUN;
                busy  <= 1'b1;
                cnt   <= CW'(DIV_CYCLES);
                op_q  <= MDUOp;
                a_q   <= A;
                b_q   <= B;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt <= CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (!res_keep) begin
              HI <= res_hi;
              LO <= res_lo;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a per-cycle reference model.
// Model tracks remaining busy cycles and the pending HI/LO result.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int          m_left;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        p_keep;

  function automatic logic [64:0] calc(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned uq;
    longint unsigned ur;
    logic [64:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (op)
      3'd1: begin q = sa * sb; res = {1'b0, q}; end
      3'd2: begin uq = ua * ub; res = {1'b0, uq}; end
      3'd3: begin
        if (b == 0) res = {1'b1, 64'b0};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {1'b0, r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (b == 0) res = {1'b1, 64'b0};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {1'b0, ur[31:0], uq[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      p_keep <= 1'b0;
      p_hi   <= '0;
      p_lo   <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && !p_keep) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (start) begin
      case (MDUOp)
        3'd1, 3'd2, 3'd3, 3'd4: begin
          {p_keep, p_hi, p_lo} <= calc(MDUOp, A, B);
          m_left <= (MDUOp <= 3'd2) ? MC : DC;
        end
        3'd5: m_hi <= A;
        3'd6: m_lo <= A;
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", {31'b0, busy}, {31'b0, (m_left != 0)});
      chk("model_hi", HI, m_hi);
      chk("model_lo", LO, m_lo);
    end
  end

  // Call at a negedge; request is accepted at the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1;
    MDUOp = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    MDUOp = 3'd0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_done(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_done: busy stuck high after 100 cycles");
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int ncyc, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int n;
    issue(op, a, b);
    wait_done(n);
    chk({nm, "_cycles"}, n, ncyc);
    chk({nm, "_hi"}, HI, ehi);
    chk({nm, "_lo"}, LO, elo);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start = 1'b0;
    MDUOp = 3'd0;
    A = '0;
    B = '0;
    #3;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    issue(3'd5, 32'h11, 32'h0);
    @(negedge clk);
    issue(3'd6, 32'h22, 32'h0);
    @(negedge clk);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'h11);
    chk("mtlo_lo", LO, 32'h22);

    run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, MC,
           32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, MC,
           32'hFFFFFFFE, 32'h00000001);
    run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, DC,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 3'd4, 32'd7, 32'd2, DC, 32'd1, 32'd3);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, DC,
           32'h0, 32'h80000000);

    issue(3'd5, 32'h11, 32'h0);
    @(negedge clk);
    issue(3'd6, 32'h22, 32'h0);
    @(negedge clk);
    run_op("div0", 3'd3, 32'd1234, 32'd0, DC, 32'h11, 32'h22);
    run_op("divu0", 3'd4, 32'd99, 32'd0, DC, 32'h11, 32'h22);

    issue(3'd7, 32'hDEAD, 32'h1);
    issue(3'd0, 32'hBEEF, 32'h1);
    @(negedge clk);
    chk("nop_busy", {31'b0, busy}, 32'd0);
    chk("nop_hi", HI, 32'h11);
    chk("nop_lo", LO, 32'h22);

    issue(3'd1, 32'd6, 32'd7);
    @(negedge clk);
    issue(3'd6, 32'h99, 32'h0);
    wait_done(n);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd42);

    @(negedge clk);
    run_op("b2b_mult", 3'd1, 32'd3, 32'd4, MC, 32'd0, 32'd12);
    run_op("b2b_divu", 3'd4, 32'd100, 32'd7, DC, 32'd2, 32'd14);

    issue(3'd3, 32'd500, 32'd3);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd0);

    run_op("post_rst_mult", 3'd1, 32'd5, 32'd5, MC, 32'd0, 32'd25);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: cycles from accepted mult/multu to HI/LO update.
REQ-002 Parameter DIV_CYCLES, default 10: cycles from accepted div/divu to HI/LO update.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage request strobe, one cycle per instruction.
REQ-006 MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
REQ-007 A  input  32  E-stage forwarded rs value.
REQ-008 B  input  32  E-stage forwarded rt value.
REQ-009 busy  output  1  operation in progress; the D stage stalls any mult/div/mfhi/mflo/mthi/mtlo while (start | busy).
REQ-010 HI  output  32  current HI register.
REQ-011 LO  output  32  current LO register.

Function
REQ-012 Request accepted at a rising edge iff start=1, busy=0 and MDUOp is 1..6.
REQ-013 start with busy=1 SHALL be ignored: no state change.
REQ-014 MDUOp 0 or 7 with start=1 SHALL be a no-op.
REQ-015 mthi: HI <= A at the accepting edge, busy stays 0, LO unchanged.
REQ-016 mtlo: LO <= A at the accepting edge, busy stays 0, HI unchanged.
REQ-017 mult/multu/div/divu: A, B and op latched internally at the accepting edge; later A/B changes SHALL NOT affect the result.
REQ-018 FSM states IDLE and RUN; IDLE->RUN on an accepted mult/div op, with counter loaded to MULT_CYCLES or DIV_CYCLES.
REQ-019 In RUN, counter decrements each edge; at the edge where it would reach 0, HI/LO load the result, state->IDLE, busy->0.
REQ-020 busy SHALL be 1 for exactly N consecutive cycles, starting the cycle after acceptance (N = MULT_CYCLES or DIV_CYCLES).
REQ-021 HI/LO SHALL hold their previous values while busy=1 and become the new result in the first cycle busy=0.
REQ-022 Back-to-back: a start in the first cycle busy=0 SHALL be accepted.
REQ-023 mult: signed 32x32 -> 64-bit product; HI = bits 63:32, LO = bits 31:0.
REQ-024 multu: the same split as mult, with the product computed unsigned.
REQ-025 div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-026 div boundary: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000.
REQ-027 divu: LO = unsigned quotient, HI = unsigned remainder.
REQ-028 Divide by zero (B=0, div or divu): the full busy period SHALL elapse, with HI and LO unchanged at completion.
REQ-029 Result computation may be combinational on the latched operands; only the timing of REQ-019..021 is externally visible.

Reset
REQ-030 reset_n=0 SHALL immediately, without waiting for clk, force HI=0, LO=0, busy=0, state IDLE and counter 0.
REQ-031 Reset mid-operation SHALL discard the pending result; HI/LO remain 0 after release.
REQ-032 After reset_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-033 mult, A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 multu, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 div, A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu, A=7, B=2 -> LO=3, HI=1.
REQ-036 Preload HI=0x11, LO=0x22 via mthi/mtlo (busy never asserts); div, B=0 -> after 10 cycles HI=0x11, LO=0x22.
REQ-037 mult in flight; start mtlo while busy=1 -> ignored, LO takes the mult result. Separate case: reset_n pulsed low in cycle 3 of a div -> HI=LO=0 and busy=0 asynchronously, no later update.
REQ-038 Back-to-back: mult accepted, then divu issued in the first busy=0 cycle -> busy low for exactly 1 cycle between ops, and each result appears per REQ-020..021.
